ddr2_rd_capture: RTL and testbench
==================================

Name: ddr2_rd_capture

Overview:
- Read-data capture and alignment block for the DDR2 PHY. It is the return path from the DRAM to the controller, running opposite to the forwarded-clock output path.
- Takes rise/fall DQ samples that the input DDR registers have already brought into the `clk` domain. Tracks each issued read command through a programmable round-trip latency, then emits one full-width word per cycle with a valid strobe.
- Contains a latency-calibration FSM. It measures the read round trip against a known training pattern and locks the capture latency.

Parameters:
- DQ_WIDTH, 8, DRAM data bus width.
- BURST_LEN, 4, DRAM burst length; must be even; capture window is BURST_LEN/2 cycles.
- MAX_LAT, 15, largest supported read latency in `clk` cycles.
- LAT_W, 4, width of latency values; must satisfy 2^LAT_W > MAX_LAT.
- DEF_LAT, 6, latency used from reset until calibration locks.
- CAL_PATTERN, 16'hA55A, expected first word {fall,rise} during calibration; width 2*DQ_WIDTH.

Ports:
- clk, input, 1, PHY clock (same clock that drives the memory clock output).
- rst_n, input, 1, asynchronous active-low reset.
- dq_rise, input, DQ_WIDTH, rising-edge DQ sample, `clk` domain.
- dq_fall, input, DQ_WIDTH, falling-edge DQ sample, `clk` domain.
- rd_cmd, input, 1, single-cycle pulse when a READ is issued to the DRAM.
- cal_start, input, 1, single-cycle pulse that starts calibration.
- rd_data, output, 2*DQ_WIDTH, captured word {dq_fall, dq_rise}.
- rd_valid, output, 1, rd_data is valid this cycle.
- rd_lat, output, LAT_W, latency currently in use.
- cal_done, output, 1, calibration locked (sticky).
- cal_err, output, 1, calibration failed (sticky).
- rd_overrun, output, 1, sticky: a burst window overlapped a new one.

Behaviour:
- Reset (async, active-low) sets outputs and state as follows:
  - rd_data=0, rd_valid=0, rd_lat=DEF_LAT, cal_done=0, cal_err=0, rd_overrun=0.
  - FSM goes to IDLE; delay line and burst counter are cleared.
- Delay line: a MAX_LAT-bit shift register. rd_cmd enters at tap 1 and shifts one tap per cycle. A marker fires when the bit at tap rd_lat is 1. Pipelined back-to-back reads are supported.
- Latency definition: for rd_cmd sampled at edge N, the data word present at edge N+rd_lat is the first beat. It is registered, so rd_data/rd_valid show it in the cycle following edge N+rd_lat.
- Burst window: when the marker fires, rd_valid is asserted for BURST_LEN/2 consecutive cycles. A down-counter of width clog2(BURST_LEN/2)+1 tracks the window.
- Overlap: if a marker fires while the counter is nonzero and not in its last beat:
  - set rd_overrun;
  - reload the counter;
  - rd_valid stays high.
- Adjacent windows: a marker in the last beat of a window continues rd_valid seamlessly with no overrun.
- rd_data updates only on cycles where rd_valid is asserted and holds otherwise.
- Calibration FSM states are IDLE, ARMED, SEARCH, DONE, FAIL:
  - IDLE: cal_start moves to ARMED and clears cal_done/cal_err.
  - ARMED: waits for rd_cmd; on rd_cmd it loads the search counter k=1 and moves to SEARCH.
  - SEARCH: each cycle compares {dq_fall,dq_rise} with CAL_PATTERN.
    - On a match at count k, rd_lat takes k and the FSM moves to DONE.
    - With no match and k==MAX_LAT, the FSM moves to FAIL and rd_lat is unchanged.
    - Otherwise k increments.
  - DONE: holds cal_done=1.
  - FAIL: holds cal_err=1.
  - From DONE or FAIL, cal_start returns the FSM to ARMED.
- During ARMED and SEARCH: rd_valid is forced 0, the delay line is flushed, and further rd_cmd pulses do not enter the delay line.
- cal_start in ARMED or SEARCH restarts the FSM in ARMED.
- rd_cmd in the same cycle as cal_start is ignored.
- rd_lat changes only on calibration lock or reset. Normal reads issued after DONE use the new value.

Test Plan:
- Reset, then rd_cmd at cycle 0, DEF_LAT=6, BURST_LEN=4, beats 0x1211 then 0x3433 at edges 6 and 7 -> rd_valid high for exactly 2 cycles after edges 6 and 7, rd_data=0x1211 then 0x3433, rd_overrun=0.
- rd_cmd at cycles 0 and 2 -> rd_valid continuous for 4 cycles, rd_overrun stays 0.
- rd_cmd at cycles 0 and 1 -> rd_overrun=1, rd_valid high for 3 cycles.
- cal_start, rd_cmd at cycle 10, 0xA55A driven only at edge 19 -> rd_lat=9 and cal_done=1.
  - A subsequent read: rd_valid asserts in the cycle after edge cmd+9.
- cal_start, rd_cmd, pattern never driven -> cal_err=1 after 15 search cycles, rd_lat remains 6, rd_valid never asserted.
- Assert rst_n low mid-burst and mid-SEARCH -> all outputs return to reset values immediately, rd_lat=6, no rd_valid after release until a new rd_cmd.

Source files
------------

// File: rtl/ddr2_rd_capture.sv
// DDR2 PHY read-data capture: tracks issued reads through a programmable
// round-trip latency, emits one {fall,rise} word per beat with a valid
// strobe, and calibrates that latency against a known training pattern.
module ddr2_rd_capture #(
    parameter int                      DQ_WIDTH    = 8,
    parameter int                      BURST_LEN   = 4,
    parameter int                      MAX_LAT     = 15,
    parameter int                      LAT_W       = 4,
    parameter int                      DEF_LAT     = 6,
    parameter logic [2*DQ_WIDTH-1:0]   CAL_PATTERN = 16'hA55A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DQ_WIDTH-1:0]   dq_rise,
    input  logic [DQ_WIDTH-1:0]   dq_fall,
    input  logic                  rd_cmd,
    input  logic                  cal_start,
    output logic [2*DQ_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [LAT_W-1:0]      rd_lat,
    output logic                  cal_done,
    output logic                  cal_err,
    output logic                  rd_overrun
);

    localparam int BEATS = BURST_LEN / 2;
    localparam int CNT_W = $clog2(BEATS) + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_SEARCH = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_FAIL   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [LAT_W-1:0]      k_q, k_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [MAX_LAT:1]      dl_q, dl_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DQ_WIDTH-1:0] data_q, data_d;
    logic                  ovr_q, ovr_d;

    logic [2*DQ_WIDTH-1:0] word;
    logic                  busy_q, busy_d, flush;
    logic                  marker;

    assign word   = {dq_fall, dq_rise};
    assign busy_q = (state_q == ST_ARMED) || (state_q == ST_SEARCH);
    assign busy_d = (state_d == ST_ARMED) || (state_d == ST_SEARCH);
    // Flushing on either side of the transition keeps a rd_cmd that coincides
    // with cal_start, or with the final SEARCH cycle, out of the delay line.
    assign flush  = busy_q || busy_d;

    // Calibration FSM: cal_start from any state (re)arms and clears the flags.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        lat_d   = lat_q;
        done_d  = done_q;
        err_d   = err_q;
        if (cal_start) begin
            state_d = ST_ARMED;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
                    if (rd_cmd) begin
                        state_d = ST_SEARCH;
                        k_d     = LAT_W'(1);
                    end
                end
                ST_SEARCH: begin
                    if (word == CAL_PATTERN) begin
                        state_d = ST_DONE;
                        lat_d   = k_q;
                        done_d  = 1'b1;
                    end else if (k_q == LAT_W'(MAX_LAT)) begin
                        state_d = ST_FAIL;
                        err_d   = 1'b1;
                    end else begin
                        k_d = k_q + LAT_W'(1);
                    end
                end
                ST_DONE: ;
                ST_FAIL: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Marker: the delay-line tap selected by the current latency.
    always_comb begin
        marker = 1'b0;
        for (int unsigned t = 1; t <= MAX_LAT; t++) begin
            if (32'(lat_q) == t) marker = dl_q[t];
        end
    end

    // Delay line, burst window counter, data capture and overrun detection.
    // cnt_q holds the beats left including the one on rd_data, so rd_valid is
    // simply cnt_q != 0 and a value of 1 marks the last beat of a window.
    always_comb begin
        dl_d   = {dl_q[MAX_LAT-1:1], rd_cmd};
        cnt_d  = cnt_q;
        data_d = data_q;
        ovr_d  = ovr_q;
        if (flush) begin
            dl_d  = '0;
            cnt_d = '0;
        end else if (marker) begin
            cnt_d  = CNT_W'(BEATS);
            data_d = word;
            if (cnt_q > CNT_W'(1)) ovr_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q > CNT_W'(1)) data_d = word;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            lat_q   <= LAT_W'(DEF_LAT);
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dl_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            lat_q   <= lat_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dl_q    <= dl_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rd_data    = data_q;
    assign rd_valid   = (cnt_q != '0);
    assign rd_lat     = lat_q;
    assign cal_done   = done_q;
    assign cal_err    = err_q;
    assign rd_overrun = ovr_q;

endmodule

// File: tb/tb_ddr2_rd_capture.sv
// Directed bench for ddr2_rd_capture: read latency, burst windows, overlap,
// calibration lock/failure and asynchronous reset.
module tb_ddr2_rd_capture;

    localparam int DQ_WIDTH = 8;
    localparam int LAT_W    = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [DQ_WIDTH-1:0]   dq_rise = '0;
    logic [DQ_WIDTH-1:0]   dq_fall = '0;
    logic                  rd_cmd = 1'b0;
    logic                  cal_start = 1'b0;
    logic [2*DQ_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic [LAT_W-1:0]      rd_lat;
    logic                  cal_done;
    logic                  cal_err;
    logic                  rd_overrun;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_data = '0;

    ddr2_rd_capture #(
        .DQ_WIDTH    (8),
        .BURST_LEN   (4),
        .MAX_LAT     (15),
        .LAT_W       (4),
        .DEF_LAT     (6),
        .CAL_PATTERN (16'hA55A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dq_rise    (dq_rise),
        .dq_fall    (dq_fall),
        .rd_cmd     (rd_cmd),
        .cal_start  (cal_start),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_lat     (rd_lat),
        .cal_done   (cal_done),
        .cal_err    (cal_err),
        .rd_overrun (rd_overrun)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [15:0] beat(input int e);
        if (e == 6)      return 16'h1211;
        else if (e == 7) return 16'h3433;
        else             return 16'hC000 | 16'(e);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [15:0] w);
        {dq_fall, dq_rise} = w;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rd_data"},  32'(rd_data), 32'h0);
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'h0);
        chk({tag, " rd_lat"},   32'(rd_lat), 32'd6);
        chk({tag, " cal_done"}, 32'(cal_done), 32'h0);
        chk({tag, " cal_err"},  32'(cal_err), 32'h0);
        chk({tag, " overrun"},  32'(rd_overrun), 32'h0);
    endtask

    task automatic do_reset();
        rd_cmd = 1'b0;
        cal_start = 1'b0;
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        exp_data = '0;
    endtask

    // Drives rd_cmd per cmd_m bit for n edges; checks rd_valid, rd_data and
    // rd_overrun after each edge. Edge e samples the word beat(e).
    task automatic run_window(input string tag, input int n, input logic [31:0] cmd_m,
                              input logic [31:0] val_m, input logic [31:0] ovr_m);
        for (int e = 0; e < n; e++) begin
            rd_cmd = cmd_m[e];
            drive_word(beat(e));
            cyc();
            if (val_m[e]) exp_data = beat(e);
            chk($sformatf("%s e%0d valid", tag, e), 32'(rd_valid), 32'(val_m[e]));
            chk($sformatf("%s e%0d data", tag, e), 32'(rd_data), 32'(exp_data));
            chk($sformatf("%s e%0d ovr", tag, e), 32'(rd_overrun), 32'(ovr_m[e]));
        end
        rd_cmd = 1'b0;
    endtask

    initial begin
        // Reset values.
        cyc();
        chk_reset("por");
        do_reset();
        chk_reset("por_rel");

        // Single read, latency 6: beats at edges 6 and 7.
        run_window("single", 10, 32'h1, 32'h0C0, 32'h0);
        // Reads at 0 and 2: adjacent windows, 4 contiguous beats, no overrun.
        run_window("adjacent", 12, 32'h5, 32'h3C0, 32'h0);

        // Reads at 0 and 1: overlap, overrun from edge 7, 3 valid beats.
        do_reset();
        run_window("overlap", 12, 32'h3, 32'h1C0, 32'hFFFF_FF80);

        // Calibration: rd_cmd at edge 10, pattern only at edge 19 -> lat 9.
        // The rd_cmd at edge 12 lands in SEARCH and must never produce data.
        do_reset();
        for (int e = 0; e <= 26; e++) begin
            cal_start = (e == 0);
            rd_cmd    = (e == 10) || (e == 12);
            drive_word((e == 19) ? 16'hA55A : beat(e));
            cyc();
            chk($sformatf("cal e%0d done", e), 32'(cal_done), (e >= 19) ? 32'h1 : 32'h0);
            chk($sformatf("cal e%0d lat", e), 32'(rd_lat), (e >= 19) ? 32'd9 : 32'd6);
            chk($sformatf("cal e%0d valid", e), 32'(rd_valid), 32'h0);
            chk($sformatf("cal e%0d err", e), 32'(cal_err), 32'h0);
        end
        cal_start = 1'b0;
        rd_cmd = 1'b0;

        // Read after lock uses latency 9: beats at edges 9 and 10.
        run_window("lat9", 14, 32'h1, 32'h600, 32'h0);

        // Re-arm from DONE, reset mid-SEARCH: everything back to reset values.
        for (int e = 0; e <= 6; e++) begin
            cal_start = (e == 0);
            rd_cmd    = (e == 2);
            drive_word(16'h5AA5);
            cyc();
            chk($sformatf("rearm e%0d done", e), 32'(cal_done), 32'h0);
            chk($sformatf("rearm e%0d lat", e), 32'(rd_lat), 32'd9);
        end
        cal_start = 1'b0;
        rd_cmd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_search");
        cyc();
        rst_n = 1'b1;
        exp_data = '0;
        for (int e = 0; e < 8; e++) begin
            cyc();
            chk($sformatf("post_search e%0d valid", e), 32'(rd_valid), 32'h0);
            chk($sformatf("post_search e%0d lat", e), 32'(rd_lat), 32'd6);
        end

        // Reset mid-burst: valid after edge 6, then reset kills the window.
        for (int e = 0; e <= 6; e++) begin
            rd_cmd = (e == 0);
            drive_word(beat(e));
            cyc();
        end
        chk("burst_pre valid", 32'(rd_valid), 32'h1);
        chk("burst_pre data", 32'(rd_data), 32'h1211);
        rst_n = 1'b0;
        #1;
        chk_reset("rst_burst");
        cyc();
        rst_n = 1'b1;
        for (int e = 0; e < 10; e++) begin
            drive_word(beat(e));
            cyc();
            chk($sformatf("post_burst e%0d valid", e), 32'(rd_valid), 32'h0);
            chk($sformatf("post_burst e%0d data", e), 32'(rd_data), 32'h0);
        end

        // Calibration failure: rd_cmd with cal_start is ignored; rd_cmd at 3
        // starts SEARCH (k=1 at edge 4), k=15 at edge 18 fails.
        for (int e = 0; e <= 22; e++) begin
            cal_start = (e == 0);
            rd_cmd    = (e == 0) || (e == 3);
            drive_word(16'h5AA5);
            cyc();
            chk($sformatf("fail e%0d err", e), 32'(cal_err), (e >= 18) ? 32'h1 : 32'h0);
            chk($sformatf("fail e%0d done", e), 32'(cal_done), 32'h0);
            chk($sformatf("fail e%0d lat", e), 32'(rd_lat), 32'd6);
            chk($sformatf("fail e%0d valid", e), 32'(rd_valid), 32'h0);
        end
        cal_start = 1'b0;
        rd_cmd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
